// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Auto-repeat is enabled by defining KEYPAD_AUTO_REPEAT_EN.
package keypad_pkg;

    localparam int KEY_W = 4;
    localparam int ROWS  = 4;
    localparam int COLS  = 4;

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_DB_PRESS   = 2'd1;
    localparam logic [1:0] ST_PRESSED    = 2'd2;
    localparam logic [1:0] ST_DB_RELEASE = 2'd3;

    typedef enum logic [1:0] {
        FC_NONE,
        FC_SINGLE,
        FC_MULTI
    } frame_class_t;

    typedef struct packed {
        frame_class_t     cls;
        logic [KEY_W-1:0] key;
    } frame_t;

    // Keys consumed by the clock top level for time-set and mode control
    localparam logic [KEY_W-1:0] KEY_SET  = 4'd12;
    localparam logic [KEY_W-1:0] KEY_MODE = 4'd13;
    localparam logic [KEY_W-1:0] KEY_UP   = 4'd14;
    localparam logic [KEY_W-1:0] KEY_DOWN = 4'd15;

    function automatic frame_t classify_frame(
        input logic [ROWS*COLS-1:0] low
    );
        frame_t f;
        int     n;
        f.cls = FC_NONE;
        f.key = '0;
        n     = 0;
        for (int i = 0; i < ROWS*COLS; i++) begin
            if (low[i]) begin
                n++;
                f.key = KEY_W'(i);
            end
        end
        if (n == 1)
            f.cls = FC_SINGLE;
        else if (n > 1)
            f.cls = FC_MULTI;
        return f;
    endfunction

endpackage

// File: rtl/keypad_scanner_tick.sv
// One-cycle enable strobe every DIV clocks; keeps all logic on clk.
module scan_tick #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] cnt;

    assign tick = (cnt == W'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else
            cnt <= tick ? '0 : cnt + W'(1);
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 key matrix scanner with frame debounce and one-cycle valid strobe.
// Define KEYPAD_AUTO_REPEAT_EN to re-issue held keys periodically.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 100000,
    parameter int DEBOUNCE_CNT = 4,
    parameter int REPEAT_DELAY = 50,
    parameter int REPEAT_RATE  = 10
) (
    input  logic             clk,
    input  logic             init,
    input  logic [ROWS-1:0]  iRow,
    output logic [COLS-1:0]  oCol,
    output logic [KEY_W-1:0] oKey,
    output logic             oValid,
    output logic             oHeld
);
    localparam logic [3:0] DB_LAST = 4'(DEBOUNCE_CNT);

    logic                 tick;
    logic [ROWS-1:0]      row_s1;
    logic [ROWS-1:0]      row_s2;
    logic [1:0]           col;
    logic [ROWS*COLS-1:0] acc;
    logic [ROWS*COLS-1:0] frame_bits;
    logic                 frame_close;
    frame_t               fr;
    logic [1:0]           state;
    logic [3:0]           cnt;
    logic [3:0]           cnt_inc;
    logic [KEY_W-1:0]     cand;
    logic                 hit;
    logic                 cand_hit;
    logic                 rep_fire;

    scan_tick #(.DIV(SCAN_DIV)) u_tick (
        .clk   (clk),
        .rst_n (init),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge init) begin
        if (!init) begin
            row_s1 <= '1;
            row_s2 <= '1;
        end else begin
            row_s1 <= iRow;
            row_s2 <= row_s1;
        end
    end

    // Earlier columns come from acc; the current column is taken live
    always_comb begin
        frame_bits = acc;
        for (int r = 0; r < ROWS; r++)
            frame_bits[r*COLS + int'(col)] = ~row_s2[r];
    end

    always_ff @(posedge clk or negedge init) begin
        if (!init) begin
            acc <= '0;
            col <= 2'd0;
        end else if (tick) begin
            acc <= frame_bits;
            col <= col + 2'd1;
        end
    end

    assign frame_close = tick && (col == 2'd3);
    assign fr          = classify_frame(frame_bits);
    assign oCol        = ~(4'b0001 << col);
    assign oHeld       = (state == ST_PRESSED) || (state == ST_DB_RELEASE);
    assign cnt_inc     = cnt + 4'd1;
    assign hit         = (fr.cls == FC_SINGLE) && (fr.key == oKey);
    assign cand_hit    = (fr.cls == FC_SINGLE) && (fr.key == cand);

`ifdef KEYPAD_AUTO_REPEAT_EN
    logic [6:0] rep_cnt;
    logic [6:0] rep_inc;

    assign rep_inc  = rep_cnt + 7'd1;
    assign rep_fire = frame_close && (state == ST_PRESSED) && hit
                      && (rep_inc == 7'(REPEAT_DELAY));

    // After a repeat, rewind so the next one lands REPEAT_RATE frames later
    always_ff @(posedge clk or negedge init) begin
        if (!init)
            rep_cnt <= '0;
        else if (frame_close) begin
            if ((state == ST_PRESSED) && hit)
                rep_cnt <= rep_fire ? 7'(REPEAT_DELAY - REPEAT_RATE)
                                    : rep_inc;
            else
                rep_cnt <= '0;
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    always_ff @(posedge clk or negedge init) begin
        if (!init) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            cand   <= '0;
            oKey   <= '0;
            oValid <= 1'b0;
        end else begin
            oValid <= rep_fire;
            if (frame_close) begin
                unique case (state)
                    ST_IDLE: begin
                        if (fr.cls == FC_SINGLE) begin
                            cand <= fr.key;
                            if (DB_LAST == 4'd1) begin
                                state  <= ST_PRESSED;
                                oKey   <= fr.key;
                                oValid <= 1'b1;
                                cnt    <= '0;
                            end else begin
                                state <= ST_DB_PRESS;
                                cnt   <= 4'd1;
                            end
                        end
                    end
                    ST_DB_PRESS: begin
                        if (!cand_hit) begin
                            state <= ST_IDLE;
                            cnt   <= '0;
                        end else if (cnt_inc == DB_LAST) begin
                            state  <= ST_PRESSED;
                            oKey   <= cand;
                            oValid <= 1'b1;
                            cnt    <= '0;
                        end else
                            cnt <= cnt_inc;
                    end
                    ST_PRESSED: begin
                        if (hit)
                            cnt <= '0;
                        else if (DB_LAST == 4'd1) begin
                            state <= ST_IDLE;
                            cnt   <= '0;
                        end else begin
                            state <= ST_DB_RELEASE;
                            cnt   <= 4'd1;
                        end
                    end
                    ST_DB_RELEASE: begin
                        if (hit) begin
                            state <= ST_PRESSED;
                            cnt   <= '0;
                        end else if (cnt_inc == DB_LAST) begin
                            state <= ST_IDLE;
                            cnt   <= '0;
                        end else
                            cnt <= cnt_inc;
                    end
                    default: begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: frame-level key model vs DUT.
// Honours KEYPAD_AUTO_REPEAT_EN in the reference model.
module tb_keypad_scanner;

    localparam int SD = 4;
    localparam int DB = 3;
    localparam int RD = 5;
    localparam int RR = 2;
    localparam int FRAME = 4 * SD;

    logic        clk  = 1'b0;
    logic        init = 1'b0;
    logic [3:0]  iRow;
    logic [3:0]  oCol;
    logic [3:0]  oKey;
    logic        oValid;
    logic        oHeld;
    logic [15:0] keys = '0;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {
        logic [3:0] key;
        int         t;
    } exp_t;

    exp_t q[$];
    exp_t e;

    int m_cnt, m_cand, m_key, m_rep;
    bit m_held;

    always #5 clk = ~clk;

    keypad_scanner #(
        .SCAN_DIV     (SD),
        .DEBOUNCE_CNT (DB),
        .REPEAT_DELAY (RD),
        .REPEAT_RATE  (RR)
    ) dut (
        .clk    (clk),
        .init   (init),
        .iRow   (iRow),
        .oCol   (oCol),
        .oKey   (oKey),
        .oValid (oValid),
        .oHeld  (oHeld)
    );

    // Passive matrix: a pressed key shorts its row to its driven-low column
    always_comb begin
        iRow = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4 + c] && !oCol[c])
                    iRow[r] = 1'b0;
    end

    always @(posedge clk or negedge init) begin
        if (!init)
            cyc <= 0;
        else
            cyc <= cyc + 1;
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        m_cnt  = 0;
        m_cand = 0;
        m_key  = 0;
        m_rep  = 0;
        m_held = 0;
    endfunction

    // One whole frame of key state; t is the cycle its valid would appear
    function automatic void model_frame(input logic [15:0] k, input int t);
        int n;
        int idx;
        bit fire;
        exp_t x;
        n    = $countones(k);
        idx  = 0;
        fire = 0;
        for (int i = 0; i < 16; i++)
            if (k[i]) idx = i;
        if (!m_held) begin
            if (m_cnt == 0) begin
                if (n == 1) begin
                    m_cand = idx;
                    m_cnt  = 1;
                end
            end else if (n == 1 && idx == m_cand)
                m_cnt++;
            else
                m_cnt = 0;
            if (m_cnt == DB) begin
                m_held = 1;
                m_key  = m_cand;
                m_cnt  = 0;
                m_rep  = 0;
                fire   = 1;
            end
        end else if (n == 1 && idx == m_key) begin
            if (m_cnt == 0) begin
                m_rep++;
`ifdef KEYPAD_AUTO_REPEAT_EN
                if (m_rep >= RD && (m_rep - RD) % RR == 0)
                    fire = 1;
`endif
            end
            m_cnt = 0;
        end else begin
            m_cnt++;
            m_rep = 0;
            if (m_cnt == DB) begin
                m_held = 0;
                m_cnt  = 0;
            end
        end
        if (fire) begin
            x.key = 4'(m_key);
            x.t   = t;
            q.push_back(x);
        end
    endfunction

    task automatic run_frame(input logic [15:0] k);
        keys = k;
        model_frame(k, cyc + FRAME);
        repeat (FRAME) @(negedge clk);
        chk("held", int'(oHeld), int'(m_held));
        chk("key", int'(oKey), m_key);
    endtask

    task automatic check_reset_outputs();
        chk("rst_col", int'(oCol), 14);
        chk("rst_key", int'(oKey), 0);
        chk("rst_valid", int'(oValid), 0);
        chk("rst_held", int'(oHeld), 0);
    endtask

    task automatic do_reset(input int mid);
        repeat (mid) @(negedge clk);
        #1;
        chk("pending_before_reset", q.size(), 0);
        init = 1'b0;
        #1;
        check_reset_outputs();
        q.delete();
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs();
        init = 1'b1;
    endtask

    // Monitor: column walk, strobe shape, and valid/key against the queue
    logic [3:0] ec;
    logic       prev_v = 1'b0;

    always @(negedge clk) begin
        if (init && cyc > 0) begin
            ec = ~(4'b0001 << ((cyc / 4) % 4));
            chk("col", int'(oCol), int'(ec));
            if (oValid) begin
                chk("valid_gap", int'(prev_v), 0);
                chk("valid_expected", int'(q.size() > 0), 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("valid_time", cyc, e.t);
                    chk("valid_key", int'(oKey), int'(e.key));
                end
            end else if (q.size() > 0 && q[0].t <= cyc) begin
                chk("valid_missing", int'(oValid), 1);
                void'(q.pop_front());
            end
        end
        prev_v = oValid;
    end

    logic [15:0] nk;
    logic [15:0] one;
    logic [15:0] prev_k;

    initial begin
        model_reset();
        one = 16'h0001;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        init = 1'b1;

        repeat (4) run_frame('0);

        repeat (5) run_frame(one << 9);
        repeat (4) run_frame('0);

        for (int i = 0; i < 10; i++)
            run_frame((i % 2 == 0) ? (one << 5) : 16'h0000);
        repeat (4) run_frame(one << 5);
        repeat (4) run_frame('0);

        repeat (3) run_frame(16'h8001);
        repeat (4) run_frame(16'h0001);
        repeat (4) run_frame('0);

        repeat (2) run_frame(one << 7);
        do_reset(5);
        repeat (4) run_frame(one << 7);
        repeat (4) run_frame('0);

        repeat (12) run_frame(one << 3);
        repeat (4) run_frame('0);

        prev_k = '0;
        for (int i = 0; i < 200; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 5)
                nk = prev_k;
            else if (r < 7)
                nk = '0;
            else if (r < 9)
                nk = one << $urandom_range(0, 15);
            else
                nk = (one << $urandom_range(0, 15)) | (one << $urandom_range(0, 15));
            run_frame(nk);
            prev_k = nk;
        end
        repeat (4) run_frame('0);

        @(negedge clk);
        #1;
        chk("pending_at_end", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
